// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared constants, FSM encoding and response byte selection for the UART ALU
package uart_alu_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_DONE = 2'd3;
    localparam logic [15:0] RESP_LEN = 16'd8;
    localparam logic [7:0] RESERVED_BYTE = 8'h00;
    localparam int RESP_BYTES = 8;
    localparam int IDX_W = $clog2(RESP_BYTES);
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    function automatic logic [7:0] resp_byte(input logic [IDX_W-1:0] idx, input logic [7:0] opcode,
                                             input logic [31:0] result);
        logic [63:0] pkt;
        pkt = {result, RESP_LEN, RESERVED_BYTE, opcode};
        return pkt[idx*8 +: 8];
    endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter that can chain the next byte in the cycle it signals done
module uart_tx_serializer
    import uart_alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    logic [BW-1:0] baud_q, baud_d;
    logic [3:0] bit_q, bit_d;
    logic [8:0] sh_q, sh_d;
    logic tx_q, tx_d, busy_q, busy_d;
    logic bit_end, load;

    // Bit 0 is the start bit, 1..8 data, 9 the stop bit; sh_q holds {stop, data} still to go out.
    always_comb begin
        bit_end = busy_q && baud_q == BAUD_MAX;
        done_o  = bit_end && bit_q == 4'd9;
        load    = start_i && (!busy_q || done_o);
        baud_d  = (load || bit_end) ? '0 : busy_q ? baud_q + 1'b1 : baud_q;
        bit_d   = (load || done_o) ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
        sh_d    = load ? {1'b1, data_i} : bit_end ? {1'b0, sh_q[8:1]} : sh_q;
        tx_d    = load ? 1'b0 : done_o ? 1'b1 : bit_end ? sh_q[0] : tx_q;
        busy_d  = load || (busy_q && !done_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
endmodule

// File: rtl/uart_alu_resp_tx.sv
// uart_alu_resp_tx: frames an ALU result into an 8-byte response packet and sends it as 8N1 UART
module uart_alu_resp_tx
    import uart_alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode_i,
    input  logic [31:0] result_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        tx_o
);
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 2");
    end

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0] opcode_q, opcode_d;
    logic [31:0] result_q, result_d;
    logic last, hs, chain, ser_start, ser_busy, ser_done;
    logic [7:0] ser_data;

    // Bytes after the first are handed over on the done pulse itself, so the line never idles mid-packet.
    always_comb begin
        last      = idx_q == IDX_W'(RESP_BYTES - 1);
        hs        = valid_i && state_q == ST_IDLE;
        chain     = state_q == ST_SEND && ser_done && !last;
        ser_start = state_q == ST_LOAD || chain;
        ser_data  = resp_byte(chain ? idx_q + 1'b1 : idx_q, opcode_q, result_q);
        opcode_d  = hs ? opcode_i : opcode_q;
        result_d  = hs ? result_i : result_q;
        idx_d     = hs ? '0 : chain ? idx_q + 1'b1 : idx_q;
        state_d   = state_q == ST_IDLE ? (valid_i ? ST_LOAD : ST_IDLE)
                  : state_q == ST_LOAD ? ST_SEND
                  : state_q == ST_SEND ? ((ser_done && last) ? ST_DONE : ST_SEND)
                  : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            opcode_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
        end
    end

    uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .data_i  (ser_data),
        .start_i (ser_start),
        .tx_o    (tx_o),
        .busy_o  (ser_busy),
        .done_o  (ser_done)
    );

    assign ready_o = state_q == ST_IDLE;
    assign busy_o  = state_q != ST_IDLE || ser_busy;
endmodule

// File: tb/tb_uart_alu_resp_tx.sv
// tb_uart_alu_resp_tx: directed packets with a byte scoreboard fed by stimulus and drained by a UART line monitor
module tb_uart_alu_resp_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_i = 1'b0;
    logic [7:0] opcode_i = '0;
    logic [31:0] result_i = '0;
    logic ready_o, busy_o, tx_o;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_alu_resp_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode_i (opcode_i),
        .result_i (result_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .tx_o     (tx_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [7:0] op, input logic [31:0] res);
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
        exp_q.push_back(res[23:16]);
        exp_q.push_back(res[31:24]);
    endtask

    // Monitor: samples tx_o every falling edge, every bit must hold for CPB samples.
    int cyc = 0;
    int pkt_byte = 0;
    int idle_cnt = 0;
    bit in_frame = 1'b0;
    bit width_err = 1'b0;
    logic [9:0] frm = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            pkt_byte = 0;
            idle_cnt = 0;
        end else if (!in_frame) begin
            if (tx_o === 1'b0) begin
                if (pkt_byte != 0) check("gap", idle_cnt, 0);
                in_frame = 1'b1;
                cyc = 1;
                frm = '0;
                width_err = 1'b0;
            end else idle_cnt++;
        end else begin
            if (cyc % CPB == 0) frm[cyc/CPB] = tx_o;
            else if (tx_o !== frm[cyc/CPB]) width_err = 1'b1;
            cyc++;
            if (cyc == 10 * CPB) begin
                in_frame = 1'b0;
                idle_cnt = 0;
                check("stop", frm[9], 1'b1);
                check("width", width_err, 1'b0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte: got %0h expected none", frm[8:1]);
                end else check("byte", frm[8:1], exp_q.pop_front());
                pkt_byte = (pkt_byte == 7) ? 0 : pkt_byte + 1;
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [31:0] res);
        int k;
        k = 0;
        while (ready_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", ready_o, 1'b1);
        opcode_i = op;
        result_i = res;
        valid_i = 1'b1;
        push_pkt(op, res);
        @(negedge clk);
        valid_i = 1'b0;
        check("load", {tx_o, ready_o, busy_o}, 3'b101);
        @(negedge clk);
        check("start_lat", tx_o, 1'b0);
        k = 1;
        while (ready_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("ready_ret", k, 322);
    endtask

    initial begin
        int k;
        @(negedge clk);
        check("reset", {tx_o, ready_o, busy_o}, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", {tx_o, ready_o, busy_o}, 3'b110);
        end

        send(8'hA0, 32'h1234_5678);

        opcode_i = 8'h11;
        result_i = 32'hAABB_CCDD;
        valid_i = 1'b1;
        push_pkt(8'h11, 32'hAABB_CCDD);
        @(negedge clk);
        opcode_i = 8'h55;
        result_i = 32'hDEAD_BEEF;
        check("held_busy", ready_o, 1'b0);
        repeat (150) @(negedge clk);
        opcode_i = 8'h66;
        result_i = 32'hCAFE_F00D;
        repeat (150) @(negedge clk);
        opcode_i = 8'h33;
        result_i = 32'h0102_0304;
        k = 300;
        while (ready_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("held_ready", k, 322);
        push_pkt(8'h33, 32'h0102_0304);
        @(negedge clk);
        valid_i = 1'b0;
        check("held_accept", ready_o, 1'b0);
        k = 0;
        while (ready_o !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("held_ret", k, 322);

        opcode_i = 8'hC3;
        result_i = 32'h55AA_0000;
        valid_i = 1'b1;
        push_pkt(8'hC3, 32'h55AA_0000);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (214) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_tx", tx_o, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_async", {tx_o, ready_o, busy_o}, 3'b110);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h5A, 32'h8765_4321);

        send(8'h00, 32'hFFFF_FFFF);

        repeat (20) @(negedge clk);
        check("leftover", exp_q.size(), 0);
        check("mon_idle", in_frame, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
